// File: rtl/wb_stage_pkg.sv
// Shared CPU definitions used by the write-back stage.
//   XLEN/REG_W/LDT_W : datapath, register-number and load-type widths
//   ld_type_e        : load-type encodings carried down the pipeline
//   wb_payload_t     : instruction fields latched into WB
package wb_stage_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned LDT_W = 3;

  // Encodings 6 and 7 are not listed and behave like LD_NONE.
  typedef enum logic [LDT_W-1:0] {
    LD_NONE = 3'd0,
    LD_LB   = 3'd1,
    LD_LBU  = 3'd2,
    LD_LH   = 3'd3,
    LD_LHU  = 3'd4,
    LD_LW   = 3'd5
  } ld_type_e;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [REG_W-1:0] dest;
    logic             rf_we;
    logic [LDT_W-1:0] ld_type;
    logic [XLEN-1:0]  res;
    logic [XLEN-1:0]  rdata;
  } wb_payload_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// Load data alignment: picks the byte/halfword addressed by addr_lo out of the
// memory read word and sign/zero-extends it; non-loads pass res through.
//   ld_type [2:0]  load type (ld_type_e encoding)
//   addr_lo [1:0]  low address bits of the access
//   rdata   [31:0] data-memory read word
//   res     [31:0] ALU/address result
//   wdata   [31:0] value to write back
module load_align
  import wb_stage_pkg::*;
(
  input  logic [LDT_W-1:0] ld_type,
  input  logic [1:0]       addr_lo,
  input  logic [XLEN-1:0]  rdata,
  input  logic [XLEN-1:0]  res,
  output logic [XLEN-1:0]  wdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Sub-word selection and extension
  always_comb begin
    w_byte = 8'h00;
    w_half = 16'h0000;
    wdata  = res;

    case (addr_lo)
      2'd0:    w_byte = rdata[7:0];
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      default: w_byte = rdata[31:24];
    endcase

    // Halfword accesses ignore addr_lo[0]
    w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (ld_type)
      LD_LB:   wdata = {{24{w_byte[7]}}, w_byte};
      LD_LBU:  wdata = {24'h000000, w_byte};
      LD_LH:   wdata = {{16{w_half[15]}}, w_half};
      LD_LHU:  wdata = {16'h0000, w_half};
      LD_LW:   wdata = rdata;
      default: wdata = res;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back pipeline stage: latches the MEM-stage instruction, aligns load
// data, drives the register-file write port, bypass info, a retired-instruction
// counter and the debug retire trace.
//   Clk, resetn                      clock, async active-low reset
//   mem_valid/mem_* inputs           instruction handed over by MEM
//   wb_allowin                       WB can accept an instruction this cycle
//   wb_hold, wb_flush                stall request, exception kill
//   rf_we/rf_waddr/rf_wdata          register-file write port
//   fwd_valid/fwd_dest/fwd_data      bypass info to decode
//   retire_cnt                       retired-instruction count (wraps)
//   dbg_pc/dbg_we/dbg_wnum/dbg_wdata retire trace (zero when TRACE_EN=0)
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter bit          TRACE_EN = 1'b1,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              Clk,
  input  logic              resetn,
  input  logic              mem_valid,
  output logic              wb_allowin,
  input  logic [XLEN-1:0]   mem_pc,
  input  logic [REG_W-1:0]  mem_dest,
  input  logic              mem_rf_we,
  input  logic [XLEN-1:0]   mem_res,
  input  logic [LDT_W-1:0]  mem_ld_type,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              wb_hold,
  input  logic              wb_flush,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_dest,
  output logic [XLEN-1:0]   fwd_data,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic [XLEN-1:0]   dbg_pc,
  output logic [3:0]        dbg_we,
  output logic [REG_W-1:0]  dbg_wnum,
  output logic [XLEN-1:0]   dbg_wdata
);

  logic              r_valid;
  wb_payload_t       r_wb;
  logic [CNT_W-1:0]  r_retire_cnt;

  logic              w_ready_go;
  logic              w_allowin;
  logic              w_dest_nz;
  logic              w_retire;
  logic [XLEN-1:0]   w_wdata;

  assign w_ready_go = ~wb_hold;
  assign w_allowin  = ~r_valid | w_ready_go;
  assign w_dest_nz  = (r_wb.dest != '0);
  // A flushed instruction leaves WB without counting as retired
  assign w_retire   = r_valid & w_ready_go & ~wb_flush;

  // Pipeline register; flush beats capture for the valid bit
  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      r_valid <= 1'b0;
      r_wb    <= '0;
    end else begin
      if (wb_flush) begin
        r_valid <= 1'b0;
      end else if (w_allowin) begin
        r_valid <= mem_valid;
      end
      if (w_allowin) begin
        r_wb <= '{pc:      mem_pc,
                  dest:    mem_dest,
                  rf_we:   mem_rf_we,
                  ld_type: mem_ld_type,
                  res:     mem_res,
                  rdata:   mem_rdata};
      end
    end
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      r_retire_cnt <= '0;
    end else if (w_retire) begin
      r_retire_cnt <= r_retire_cnt + CNT_W'(1);
    end
  end

  load_align u_load_align (
    .ld_type (r_wb.ld_type),
    .addr_lo (r_wb.res[1:0]),
    .rdata   (r_wb.rdata),
    .res     (r_wb.res),
    .wdata   (w_wdata)
  );

  assign wb_allowin = w_allowin;
  assign rf_we      = r_valid & r_wb.rf_we & w_ready_go & ~wb_flush & w_dest_nz;
  assign rf_waddr   = r_wb.dest;
  assign rf_wdata   = w_wdata;

  // Bypass stays visible while held so decode keeps seeing the pending write
  assign fwd_valid  = r_valid & r_wb.rf_we & w_dest_nz;
  assign fwd_dest   = r_wb.dest;
  assign fwd_data   = w_wdata;

  assign retire_cnt = r_retire_cnt;

  if (TRACE_EN) begin : g_trace
    assign dbg_pc    = r_wb.pc;
    assign dbg_we    = {4{rf_we}};
    assign dbg_wnum  = r_wb.dest;
    assign dbg_wdata = w_wdata;
  end else begin : g_no_trace
    assign dbg_pc    = '0;
    assign dbg_we    = '0;
    assign dbg_wnum  = '0;
    assign dbg_wdata = '0;
  end

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
  import wb_stage_pkg::*;

  logic        Clk = 1'b0;
  logic        resetn;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic [4:0]  mem_dest;
  logic        mem_rf_we;
  logic [31:0] mem_res;
  logic [2:0]  mem_ld_type;
  logic [31:0] mem_rdata;
  logic        wb_hold;
  logic        wb_flush;

  logic        wb_allowin, rf_we, fwd_valid;
  logic [4:0]  rf_waddr, fwd_dest, dbg_wnum;
  logic [31:0] rf_wdata, fwd_data, retire_cnt, dbg_pc, dbg_wdata;
  logic [3:0]  dbg_we;

  // Second instance: narrow counter, trace disabled
  logic        s_allowin, s_rf_we, s_fwd_valid;
  logic [4:0]  s_rf_waddr, s_fwd_dest, s_dbg_wnum;
  logic [31:0] s_rf_wdata, s_fwd_data, s_dbg_pc, s_dbg_wdata;
  logic [1:0]  s_retire_cnt;
  logic [3:0]  s_dbg_we;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned exp_cnt  = 0;

  always #5 Clk = ~Clk;

  wb_stage dut (
    .Clk(Clk), .resetn(resetn), .mem_valid(mem_valid), .wb_allowin(wb_allowin),
    .mem_pc(mem_pc), .mem_dest(mem_dest), .mem_rf_we(mem_rf_we), .mem_res(mem_res),
    .mem_ld_type(mem_ld_type), .mem_rdata(mem_rdata), .wb_hold(wb_hold),
    .wb_flush(wb_flush), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
    .retire_cnt(retire_cnt), .dbg_pc(dbg_pc), .dbg_we(dbg_we),
    .dbg_wnum(dbg_wnum), .dbg_wdata(dbg_wdata)
  );

  wb_stage #(.TRACE_EN(1'b0), .CNT_W(2)) dut_small (
    .Clk(Clk), .resetn(resetn), .mem_valid(mem_valid), .wb_allowin(s_allowin),
    .mem_pc(mem_pc), .mem_dest(mem_dest), .mem_rf_we(mem_rf_we), .mem_res(mem_res),
    .mem_ld_type(mem_ld_type), .mem_rdata(mem_rdata), .wb_hold(wb_hold),
    .wb_flush(wb_flush), .rf_we(s_rf_we), .rf_waddr(s_rf_waddr), .rf_wdata(s_rf_wdata),
    .fwd_valid(s_fwd_valid), .fwd_dest(s_fwd_dest), .fwd_data(s_fwd_data),
    .retire_cnt(s_retire_cnt), .dbg_pc(s_dbg_pc), .dbg_we(s_dbg_we),
    .dbg_wnum(s_dbg_wnum), .dbg_wdata(s_dbg_wdata)
  );

  typedef struct {
    logic [2:0]  ld;
    logic [31:0] res;
    logic [31:0] rdata;
    logic [4:0]  dest;
    logic        we;
    logic        exp_we;
    logic [31:0] exp_data;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] ld, input logic [31:0] res,
                       input logic [31:0] rdata, input logic [4:0] dest,
                       input logic we, input logic [31:0] pc);
    mem_valid   = v;
    mem_ld_type = ld;
    mem_res     = res;
    mem_rdata   = rdata;
    mem_dest    = dest;
    mem_rf_we   = we;
    mem_pc      = pc;
  endtask

  task automatic chk_cnt(input string name);
    chk(name, retire_cnt, exp_cnt);
    chk({name, "_small"}, 32'(s_retire_cnt), 32'(2'(exp_cnt)));
  endtask

  initial begin
    vecs[0]  = '{LD_LB,   32'h0000_1003, 32'h80FF_1234, 5'd5,  1'b1, 1'b1, 32'hFFFF_FF80};
    vecs[1]  = '{LD_LBU,  32'h0000_1003, 32'h80FF_1234, 5'd6,  1'b1, 1'b1, 32'h0000_0080};
    vecs[2]  = '{LD_LB,   32'h0000_1000, 32'h80FF_1234, 5'd7,  1'b1, 1'b1, 32'h0000_0034};
    vecs[3]  = '{LD_LBU,  32'h0000_1001, 32'h80FF_1234, 5'd8,  1'b1, 1'b1, 32'h0000_0012};
    vecs[4]  = '{LD_LB,   32'h0000_1002, 32'h80FF_1234, 5'd9,  1'b1, 1'b1, 32'hFFFF_FFFF};
    vecs[5]  = '{LD_LHU,  32'h0000_2002, 32'h8001_7FFF, 5'd10, 1'b1, 1'b1, 32'h0000_8001};
    vecs[6]  = '{LD_LH,   32'h0000_2000, 32'h8001_7FFF, 5'd11, 1'b1, 1'b1, 32'h0000_7FFF};
    vecs[7]  = '{LD_LH,   32'h0000_2003, 32'h8001_7FFF, 5'd12, 1'b1, 1'b1, 32'hFFFF_8001};
    vecs[8]  = '{LD_LW,   32'h0000_3000, 32'hDEAD_BEEF, 5'd31, 1'b1, 1'b1, 32'hDEAD_BEEF};
    vecs[9]  = '{LD_NONE, 32'h1234_5678, 32'hFFFF_FFFF, 5'd1,  1'b1, 1'b1, 32'h1234_5678};
    vecs[10] = '{3'd6,    32'hCAFE_F00D, 32'h1111_1111, 5'd2,  1'b1, 1'b1, 32'hCAFE_F00D};
    vecs[11] = '{LD_LW,   32'h0000_4000, 32'hA5A5_A5A5, 5'd0,  1'b1, 1'b0, 32'hA5A5_A5A5};
    vecs[12] = '{LD_NONE, 32'h0000_0099, 32'h0000_0000, 5'd9,  1'b0, 1'b0, 32'h0000_0099};

    resetn   = 1'b0;
    wb_hold  = 1'b0;
    wb_flush = 1'b0;
    drive(1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);

    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_allowin", 32'(wb_allowin), 32'd1);
    chk("rst_rf_we",   32'(rf_we),      32'd0);
    chk("rst_fwd",     32'(fwd_valid),  32'd0);
    chk("rst_dbg_we",  32'(dbg_we),     32'd0);
    chk_cnt("rst_cnt");
    @(negedge Clk);
    resetn = 1'b1;

    // Table: one instruction per cycle, each retiring as the next one enters
    for (int i = 0; i < NV; i++) begin
      @(negedge Clk);
      drive(1'b1, vecs[i].ld, vecs[i].res, vecs[i].rdata, vecs[i].dest, vecs[i].we,
            32'h1C00_0000 + 32'(i) * 32'd4);
      @(posedge Clk);
      #1;
      chk($sformatf("v%0d_rf_we", i),    32'(rf_we),     32'(vecs[i].exp_we));
      chk($sformatf("v%0d_rf_waddr", i), 32'(rf_waddr),  32'(vecs[i].dest));
      chk($sformatf("v%0d_rf_wdata", i), rf_wdata,       vecs[i].exp_data);
      chk($sformatf("v%0d_fwd", i),      32'(fwd_valid), 32'(vecs[i].exp_we));
      chk($sformatf("v%0d_fwd_data", i), fwd_data,       vecs[i].exp_data);
      chk($sformatf("v%0d_dbg_pc", i),   dbg_pc,         32'h1C00_0000 + 32'(i) * 32'd4);
      chk($sformatf("v%0d_dbg_we", i),   32'(dbg_we),    {28'h0, {4{vecs[i].exp_we}}});
      chk($sformatf("v%0d_small_dbg", i), s_dbg_pc | s_dbg_wdata | 32'(s_dbg_we), 32'h0);
      chk_cnt($sformatf("v%0d_cnt", i));
      exp_cnt++;
    end
    @(negedge Clk);
    drive(1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    @(posedge Clk);
    #1;
    chk("drain_rf_we", 32'(rf_we), 32'd0);
    chk_cnt("drain_cnt");

    // Hold: ALU op stalls three cycles, then writes once
    @(negedge Clk);
    drive(1'b1, LD_NONE, 32'h55, 32'h0, 5'd3, 1'b1, 32'h100);
    @(negedge Clk);
    wb_hold = 1'b1;
    drive(1'b1, LD_NONE, 32'h66, 32'h0, 5'd4, 1'b1, 32'h104);
    for (int c = 0; c < 3; c++) begin
      @(posedge Clk);
      #1;
      chk($sformatf("hold%0d_rf_we", c),   32'(rf_we),      32'd0);
      chk($sformatf("hold%0d_fwd", c),     32'(fwd_valid),  32'd1);
      chk($sformatf("hold%0d_allowin", c), 32'(wb_allowin), 32'd0);
      chk($sformatf("hold%0d_dest", c),    32'(rf_waddr),   32'd3);
      chk_cnt($sformatf("hold%0d_cnt", c));
    end
    @(negedge Clk);
    wb_hold = 1'b0;
    drive(1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    #1;
    chk("rel_rf_we",    32'(rf_we), 32'd1);
    chk("rel_rf_wdata", rf_wdata,   32'h55);
    chk("rel_waddr",    32'(rf_waddr), 32'd3);
    @(posedge Clk);
    #1;
    exp_cnt++;
    chk_cnt("rel_cnt");
    chk("rel_after_rf_we", 32'(rf_we),     32'd0);
    chk("rel_after_fwd",   32'(fwd_valid), 32'd0);

    // Flush: valid op killed, and flush beats a new capture
    @(negedge Clk);
    drive(1'b1, LD_NONE, 32'h77, 32'h0, 5'd7, 1'b1, 32'h200);
    @(negedge Clk);
    wb_flush = 1'b1;
    drive(1'b1, LD_NONE, 32'h88, 32'h0, 5'd8, 1'b1, 32'h204);
    #1;
    chk("flush_rf_we", 32'(rf_we),     32'd0);
    chk("flush_fwd",   32'(fwd_valid), 32'd1);
    @(posedge Clk);
    #1;
    chk("flush_after_fwd", 32'(fwd_valid), 32'd0);
    chk_cnt("flush_cnt");
    @(negedge Clk);
    wb_flush = 1'b0;
    drive(1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    @(posedge Clk);
    #1;
    chk("flush_idle_rf_we", 32'(rf_we), 32'd0);
    chk_cnt("flush_idle_cnt");

    // Asynchronous reset in the middle of a stall
    @(negedge Clk);
    drive(1'b1, LD_NONE, 32'hAA, 32'h0, 5'd10, 1'b1, 32'h300);
    @(negedge Clk);
    wb_hold = 1'b1;
    drive(1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    @(posedge Clk);
    #1;
    chk("mid_fwd", 32'(fwd_valid), 32'd1);
    #2;
    resetn = 1'b0;
    exp_cnt = 0;
    #1;
    chk("arst_rf_we",   32'(rf_we),      32'd0);
    chk("arst_fwd",     32'(fwd_valid),  32'd0);
    chk("arst_allowin", 32'(wb_allowin), 32'd1);
    chk_cnt("arst_cnt");
    @(negedge Clk);
    wb_hold = 1'b0;
    resetn  = 1'b1;
    #1;
    chk("post_rst_rf_we", 32'(rf_we), 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(posedge Clk);
      #1;
      chk($sformatf("post_rst%0d_rf_we", c), 32'(rf_we), 32'd0);
      chk_cnt($sformatf("post_rst%0d_cnt", c));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter TRACE_EN, default 1: 1 drives the debug trace outputs; 0 ties them to zero.
REQ-002 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-003 Clk  input  1  clock; all state updates on posedge.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 mem_valid  input  1  MEM stage holds a valid instruction.
REQ-006 wb_allowin  output  1  WB accepts a new instruction this cycle.
REQ-007 mem_pc  input  32  PC of the MEM instruction.
REQ-008 mem_dest  input  5  destination register number.
REQ-009 mem_rf_we  input  1  instruction writes the register file.
REQ-010 mem_res  input  32  ALU/address result.
REQ-011 mem_ld_type  input  3  load type: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW; 6-7 treated as 0.
REQ-012 mem_rdata  input  32  data-memory read word, valid with mem_valid.
REQ-013 wb_hold  input  1  stall request; WB instruction must not retire.
REQ-014 wb_flush  input  1  exception flush; kills the WB instruction.
REQ-015 rf_we, rf_waddr[4:0], rf_wdata[31:0]  output  register-file write port (We, A3, WD).
REQ-016 fwd_valid, fwd_dest[4:0], fwd_data[31:0]  output  bypass/hazard info to decode.
REQ-017 retire_cnt  output  CNT_W  retired-instruction count.
REQ-018 dbg_pc[31:0], dbg_we[3:0], dbg_wnum[4:0], dbg_wdata[31:0]  output  retire trace.

Function
REQ-019 ready_go = ~wb_hold; wb_allowin = ~wb_valid | ready_go.
REQ-020 On posedge with wb_allowin=1, wb_valid <= mem_valid and all mem_* fields, including mem_rdata, are captured; with wb_allowin=0, all registers hold.
REQ-021 wb_flush=1 at posedge forces wb_valid <= 0 regardless of mem_valid; it has priority over capture.
REQ-022 Load alignment uses res[1:0]: LB/LBU select byte res[1:0], sign- or zero-extended; LH/LHU select halfword res[1], sign- or zero-extended, ignoring res[0]; LW the full word; type 0 yields res.
REQ-023 rf_wdata = aligned value; rf_waddr = captured dest; both are combinational from WB registers.
REQ-024 rf_we = wb_valid & we_r & ready_go & ~wb_flush & (dest != 0), so the write happens exactly once, on the retire edge.
REQ-025 fwd_valid = wb_valid & we_r & (dest != 0), independent of wb_hold; fwd_data = rf_wdata; fwd_dest = dest.
REQ-026 retire_cnt increments by 1 on each posedge where wb_valid & ready_go & ~wb_flush, and wraps modulo 2^CNT_W.
REQ-027 dbg_pc = captured pc; dbg_we = {4{rf_we}}; dbg_wnum = rf_waddr; dbg_wdata = rf_wdata.
REQ-028 Write latency: an instruction accepted at edge N writes the register file at edge N+1 when not held.
REQ-029 Back-to-back: at most one instruction enters per cycle; retire and capture at the same edge are legal.

Reset
REQ-030 resetn low asynchronously clears wb_valid, we_r, dest, ld_type, pc, res, rdata and retire_cnt to 0.
REQ-031 While resetn is low: rf_we=0, fwd_valid=0, wb_allowin=1, dbg_we=0.
REQ-032 Reset mid-stall discards the held instruction without writing it.

Structure
REQ-033 Load-type encodings (LD_NONE..LD_LW) and the register-number width belong in the shared CPU package.
REQ-034 Byte/halfword selection and extension are a combinational sub-module, load_align (inputs: ld_type, addr_lo, rdata, res; output: wdata).

Verification
REQ-035 LB: res=0x1003, rdata=0x80FF_1234, dest=5 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xFFFF_FF80.
REQ-036 LHU: res=0x2002, rdata=0x8001_7FFF -> rf_wdata=0x0000_8001; LH at res=0x2000 -> 0x0000_7FFF.
REQ-037 Hold: accept ALU op (res=0x55, dest=3), wb_hold=1 for 3 cycles -> rf_we=0, fwd_valid=1, wb_allowin=0; release -> one write, retire_cnt +1.
REQ-038 Flush: valid op dest=7 with wb_flush=1 -> rf_we=0 that cycle, wb_valid=0 next, retire_cnt unchanged.
REQ-039 dest=0 with mem_rf_we=1 -> rf_we=0, fwd_valid=0, retire_cnt +1.
REQ-040 Assert resetn=0 asynchronously mid-hold -> rf_we and retire_cnt are 0 immediately; no write after release.
